// File: rtl/conv1_fmap_reader_if.sv
// Bus bundle for the conv1 feature-map reader: the bank-store read port
// (rden/address2/rddata) plus the outgoing pixel stream with its sideband.
// master = the reader, slave = the bank store and downstream consumer.
interface conv1_fmap_reader_if #(
    parameter int CH = 64,
    parameter int DW = 16,
    parameter int AW = 32
);
    logic               rden;
    logic [AW-1:0]      address2;
    logic [CH*DW-1:0]   rddata;
    logic               out_valid;
    logic               out_ready;
    logic [CH*DW-1:0]   out_data;
    logic [6:0]         out_row;
    logic [6:0]         out_col;
    logic               out_eol;
    logic               out_last;

    modport master (
        output rden, address2, out_valid, out_data, out_row, out_col, out_eol, out_last,
        input  rddata, out_ready
    );

    modport slave (
        input  rden, address2, out_valid, out_data, out_row, out_col, out_eol, out_last,
        output rddata, out_ready
    );
endinterface

// File: rtl/conv1_fmap_reader.sv
// Read-side sequencer for the conv1 output feature-map bank store.
// Scans every pixel in raster order, captures the combinational 64-channel
// read word and presents it as a valid/ready stream with row/col/eol/last.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; scan counters cleared when start is taken
// RUN   | issuing reads, one per free output slot
// DRAIN | last pixel captured, waiting for downstream to take it
// DONE  | one-cycle done pulse, then back to IDLE
module conv1_fmap_reader #(
    parameter int WIDTH  = 111,
    parameter int HEIGHT = 111,
    parameter int CH     = 64,
    parameter int DW     = 16,
    parameter int AW     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    conv1_fmap_reader_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);
    localparam logic [6:0]    LAST_COL  = 7'(WIDTH - 1);

    state_t        state_q;
    state_t        state_d;
    logic [6:0]    row_q;
    logic [6:0]    col_q;
    logic [AW-1:0] addr_q;
    logic          load;
    logic          last_pix;
    logic          accept;

    // A read is issued whenever the output slot is empty or being emptied,
    // so the captured word can never overwrite an unaccepted beat.
    assign load     = (state_q == RUN) && (!bus.out_valid || bus.out_ready);
    assign last_pix = (addr_q == LAST_ADDR);
    assign accept   = bus.out_valid && bus.out_ready;

    assign bus.address2 = addr_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (load && last_pix) state_d = DRAIN;
            DRAIN:   if (accept) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status and read-enable outputs decoded from the current state.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        bus.rden = 1'b0;
        case (state_q)
            RUN: begin
                busy     = 1'b1;
                bus.rden = load;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Raster scan counters; they stop on the last pixel rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else if (state_q == IDLE && start) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else if (load && !last_pix) begin
            addr_q <= addr_q + AW'(1);
            if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_q + 7'd1;
            end else begin
                col_q <= col_q + 7'd1;
            end
        end
    end

    // Output beat register: capture on load, drop valid once taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
            bus.out_eol   <= 1'b0;
            bus.out_last  <= 1'b0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.rddata;
            bus.out_row   <= row_q;
            bus.out_col   <= col_q;
            bus.out_eol   <= (col_q == LAST_COL);
            bus.out_last  <= last_pix;
        end else if (accept) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv1_fmap_reader.sv
// Self-checking bench for conv1_fmap_reader: a full 111x111 instance driven
// through several frame scenarios, plus a 4x3 instance checked against a
// hand-written beat table.
module tb_conv1_fmap_reader;

    localparam int N  = 12321;
    localparam int W  = 111;

    logic clk = 1'b0;
    logic rst;
    logic start_a, busy_a, done_a;
    logic start_b, busy_b, done_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    conv1_fmap_reader_if #(.CH(64), .DW(16), .AW(32)) bus_a ();
    conv1_fmap_reader_if #(.CH(64), .DW(16), .AW(32)) bus_b ();

    conv1_fmap_reader dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (start_a),
        .busy  (busy_a),
        .done  (done_a),
        .bus   (bus_a)
    );

    conv1_fmap_reader #(.WIDTH(4), .HEIGHT(3)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (start_b),
        .busy  (busy_b),
        .done  (done_b),
        .bus   (bus_b)
    );

    // Bank store model: channel k of pixel a holds {a[9:0], k[5:0]}.
    function automatic logic [1023:0] bank_word(input logic [31:0] a);
        logic [1023:0] w;
        w = '0;
        for (int k = 0; k < 64; k++) begin
            w[k*16 +: 16] = {a[9:0], 6'(k)};
        end
        return w;
    endfunction

    assign bus_a.rddata = bank_word(bus_a.address2);
    assign bus_b.rddata = bank_word(bus_b.address2);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got_ch0=%h want_ch0=%h", nm, act[15:0], exp[15:0]);
        end
    endtask

    // mode 0: out_ready=1; mode 1: pseudo-random stalls plus a 10-cycle
    // stretch; mode 2: out_ready=1 with stray starts during the frame.
    task automatic run_frame(input int mode);
        int            cyc, beat, rd_next;
        bit            got, pv, pr, s5, s_end;
        logic [1023:0] pd;
        logic [6:0]    prow, pcol;
        logic          peol, plast;
        logic [31:0]   paddr;
        @(posedge clk); #1;
        start_a = 1'b1;
        bus_a.out_ready = 1'b1;
        cyc = 0; beat = 0; rd_next = 0;
        got = 0; pv = 0; pr = 0; s5 = 0; s_end = 0;
        pd = '0; prow = '0; pcol = '0; peol = 0; plast = 0; paddr = '0;
        while (!got && cyc < 40000) begin
            @(posedge clk); #1;
            cyc++;
            start_a = 1'b0;
            if (mode == 1)
                bus_a.out_ready = (cyc >= 200 && cyc < 210) ? 1'b0 : ($urandom_range(0, 3) != 0);
            else
                bus_a.out_ready = 1'b1;
            if (mode == 2) begin
                if (beat == 5 && !s5) begin start_a = 1'b1; s5 = 1; end
                if (beat == N - 1 && !s_end) begin start_a = 1'b1; s_end = 1; end
                if (cyc == N + 2) start_a = 1'b1;
            end
            #1;
            if (mode == 0 && cyc == 1) chk("first_rden", bus_a.rden, 1);
            if (mode == 0 && cyc == 2) chk("first_valid", bus_a.out_valid, 1);
            if (pv && !pr) begin
                chk("hold_valid", bus_a.out_valid, 1);
                chk_data("hold_data", bus_a.out_data, pd);
                chk("hold_row", bus_a.out_row, prow);
                chk("hold_col", bus_a.out_col, pcol);
                chk("hold_eol", bus_a.out_eol, peol);
                chk("hold_last", bus_a.out_last, plast);
                chk("hold_addr", bus_a.address2, paddr);
            end
            if (bus_a.out_valid && !bus_a.out_ready) chk("stall_rden", bus_a.rden, 0);
            if (bus_a.rden) begin
                chk("rd_addr", bus_a.address2, rd_next);
                rd_next++;
            end
            if (done_a) begin
                got = 1;
                chk("done_beats", beat, N);
                chk("done_reads", rd_next, N);
                chk("done_busy", busy_a, 0);
                if (mode != 1) chk("done_cycle", cyc, N + 2);
            end else begin
                chk("busy", busy_a, 1);
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                chk("beat_row", bus_a.out_row, beat / W);
                chk("beat_col", bus_a.out_col, beat % W);
                chk("beat_eol", bus_a.out_eol, (beat % W) == W - 1);
                chk("beat_last", bus_a.out_last, beat == N - 1);
                chk_data("beat_data", bus_a.out_data, bank_word(beat));
                beat++;
            end
            pv = bus_a.out_valid; pr = bus_a.out_ready;
            pd = bus_a.out_data; prow = bus_a.out_row; pcol = bus_a.out_col;
            peol = bus_a.out_eol; plast = bus_a.out_last; paddr = bus_a.address2;
        end
        if (!got) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
        start_a = 1'b0;
        #1;
        chk("done_single", done_a, 0);
        chk("idle_busy", busy_a, 0);
    endtask

    task automatic rst_mid_stall();
        int cyc, beat;
        @(posedge clk); #1;
        start_a = 1'b1;
        bus_a.out_ready = 1'b1;
        cyc = 0; beat = 0;
        while (beat < 600 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            start_a = 1'b0;
            #1;
            if (bus_a.out_valid && bus_a.out_ready) beat++;
        end
        if (beat < 600) chk("mid_timeout", 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus_a.out_ready = 1'b0;
            #1;
            chk("mid_stall_valid", bus_a.out_valid, 1);
            chk("mid_stall_rden", bus_a.rden, 0);
            chk("mid_stall_row", bus_a.out_row, 600 / W);
            chk("mid_stall_col", bus_a.out_col, 600 % W);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_a.out_ready = 1'b1;
        #1;
        chk("mid_rst_valid", bus_a.out_valid, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_addr", bus_a.address2, 0);
        chk("mid_rst_rden", bus_a.rden, 0);
        chk("mid_rst_row", bus_a.out_row, 0);
    endtask

    typedef struct {
        int row;
        int col;
        bit eol;
        bit last;
    } vec_t;

    task automatic run_small();
        vec_t vec [12];
        int   cyc, beat;
        bit   got;
        vec[0]  = '{0, 0, 0, 0};
        vec[1]  = '{0, 1, 0, 0};
        vec[2]  = '{0, 2, 0, 0};
        vec[3]  = '{0, 3, 1, 0};
        vec[4]  = '{1, 0, 0, 0};
        vec[5]  = '{1, 1, 0, 0};
        vec[6]  = '{1, 2, 0, 0};
        vec[7]  = '{1, 3, 1, 0};
        vec[8]  = '{2, 0, 0, 0};
        vec[9]  = '{2, 1, 0, 0};
        vec[10] = '{2, 2, 0, 0};
        vec[11] = '{2, 3, 1, 1};
        @(posedge clk); #1;
        start_b = 1'b1;
        bus_b.out_ready = 1'b1;
        cyc = 0; beat = 0; got = 0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            start_b = 1'b0;
            #1;
            if (bus_b.out_valid && bus_b.out_ready) begin
                if (beat < 12) begin
                    chk("small_row", bus_b.out_row, vec[beat].row);
                    chk("small_col", bus_b.out_col, vec[beat].col);
                    chk("small_eol", bus_b.out_eol, vec[beat].eol);
                    chk("small_last", bus_b.out_last, vec[beat].last);
                    chk_data("small_data", bus_b.out_data, bank_word(vec[beat].row * 4 + vec[beat].col));
                end else begin
                    chk("small_extra_beat", beat, 11);
                end
                beat++;
            end
            if (done_b) begin
                got = 1;
                chk("small_done_cycle", cyc, 14);
                chk("small_done_beats", beat, 12);
            end
        end
        if (!got) chk("small_timeout", 0, 1);
        @(posedge clk); #1;
        #1;
        chk("small_done_single", done_b, 0);
        chk("small_idle_busy", busy_b, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        bus_a.out_ready = 1'($urandom_range(0, 1));
        bus_b.out_ready = 1'b1;
        @(posedge clk); #1;
        start_a = 1'($urandom_range(0, 1));
        bus_a.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start_a = 1'b1;
        start_b = 1'b1;
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rden", bus_a.rden, 0);
        chk("rst_addr", bus_a.address2, 0);
        chk("rst_valid", bus_a.out_valid, 0);
        chk_data("rst_data", bus_a.out_data, '0);
        chk("rst_row", bus_a.out_row, 0);
        chk("rst_col", bus_a.out_col, 0);
        chk("rst_eol", bus_a.out_eol, 0);
        chk("rst_last", bus_a.out_last, 0);
        chk("rst_small_valid", bus_b.out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        bus_a.out_ready = 1'b1;
        #1;
        chk("rst_start_ignored", busy_a, 0);
        @(posedge clk); #2;
        chk("rst_start_ignored2", busy_a, 0);
        chk("rst_start_ignored_small", busy_b, 0);

        run_small();
        run_frame(0);
        run_frame(1);
        run_frame(2);
        rst_mid_stall();
        run_frame(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv1_fmap_reader.md
Name: conv1_fmap_reader

Overview:
- Read-side sequencer for the conv1 output feature-map bank store (64 channel banks, 111x111 pixels, 16-bit per channel).
- On start, scans every pixel address in raster order and drives the bank store's rden/address2 read port.
- Captures the combinational 64-channel read word and presents it to the next layer as a valid/ready stream with row/col/end-of-row/last sideband.
- Sits between the conv1 bank store and the downstream pooling/conv2 stage.

Parameters:
- WIDTH, 111, feature-map columns.
- HEIGHT, 111, feature-map rows.
- CH, 64, channels (banks) per pixel word.
- DW, 16, bits per channel sample.
- AW, 32, bank address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a frame scan; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- rden  out  1  read enable to the bank store.
- address2  out  AW  bank read address (linear pixel index row*WIDTH+col).
- rddata  in  CH*DW  combinational bank read word; channel k at bits [k*DW +: DW].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat when out_valid && out_ready.
- out_data  out  CH*DW  captured pixel word; channel packing same as rddata.
- out_row  out  7  row index of the beat.
- out_col  out  7  column index of the beat.
- out_eol  out  1  beat is the last column of its row.
- out_last  out  1  beat is the final pixel of the frame.

Behaviour:
- Reset values: busy=0, done=0, rden=0, address2=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_eol=0, out_last=0; FSM=IDLE; scan counters=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN; clear row/col/address counters to 0.
  - busy rises in the following cycle.
- load condition: load = (state==RUN) && (!out_valid || out_ready).
- rden = load, combinational. address2 is the registered scan address and holds when not loading.
- On each load edge:
  - out_data <= rddata, out_valid <= 1.
  - out_row/out_col <= current counters; out_eol <= (col==WIDTH-1); out_last <= (address==WIDTH*HEIGHT-1).
  - Advance counters: col wraps to 0 at WIDTH-1 and row increments; address increments by 1.
- RUN -> DRAIN on the load of address WIDTH*HEIGHT-1. Counters do not advance past the last pixel.
- Outside load, an accepted beat (out_valid && out_ready) clears out_valid.
- Backpressure: while out_valid && !out_ready, every out_* signal and address2 hold stable and rden=0. No beat is dropped or duplicated.
- DRAIN: waits until the last beat is accepted, then -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, then -> IDLE.
- Timing:
  - start at cycle 0 -> rden/address2=0 at cycle 1 -> first out_valid at cycle 2.
  - With out_ready held high, one beat per cycle.
  - Frame of N=WIDTH*HEIGHT beats completes with done at cycle N+2.
- start while busy or in DONE: ignored, no restart.
- rst asserted in any state, including mid-frame or mid-stall: next edge returns all outputs to reset values and FSM to IDLE. A pending beat is discarded.
- No write-port interaction. The frame must not be rewritten during a scan.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all outputs 0, FSM idle; start in the same cycle as rst has no effect.
- Full frame, out_ready=1, bank word k = {address[9:0], k[5:0]}:
  - exactly 12321 beats, addresses 0..12320 in order, data matches per beat.
  - out_eol on every col=110; out_last only on beat 12320 (row 110, col 110).
  - done pulses at cycle 12323 after start.
- Backpressure, out_ready toggling pseudo-randomly (incl. 10-cycle low stretch):
  - outputs and address2 stable while stalled, rden=0 during the stall.
  - sequence identical to the no-stall run; done after the final accept only.
- start pulsed at beats 5 and 12320 of a running scan -> ignored; single 12321-beat frame, single done.
- rst at beat 600 while stalled -> next cycle out_valid=0, busy=0, address2=0; a new start rescans from address 0.
- WIDTH=4, HEIGHT=3 build:
  - beats (r,c) 0,0..2,3 in order; out_eol at cols 3; out_last on beat 11.
  - done at cycle 14 with out_ready=1.
